// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = X - Y - Bin (mod 2^WIDTH), one bit per clock through a single
// full-subtractor slice. Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xs, ys;
  logic [WIDTH-2:0] rs;
  logic             b;

  logic             x0, y0, d, b_nxt, last;
  logic [WIDTH-1:0] res_nxt;

  // Full-subtractor slice on the current LSBs of the operand shift registers.
  assign x0      = xs[0];
  assign y0      = ys[0];
  assign d       = x0 ^ y0 ^ b;
  assign b_nxt   = (~x0 & y0) | (~(x0 ^ y0) & b);
  assign res_nxt = {d, rs};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      xs   <= '0;
      ys   <= '0;
      rs   <= '0;
      b    <= 1'b0;
      Diff <= '0;
      Bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      Ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xs  <= X;
          ys  <= Y;
          b   <= Bin;
          cnt <= '0;
        end
        SHIFT: begin
          xs  <= xs >> 1;
          ys  <= ys >> 1;
          rs  <= res_nxt[WIDTH-1:1];
          b   <= b_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            Diff <= res_nxt;
            Bout <= b_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // On the final slice x0/y0 are the original operand MSBs and d is the result MSB.
            Ovf  <= (x0 ^ y0) & (x0 ^ d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an arithmetic reference model checked every cycle plus
// hand-computed literal expectations. Builds with or without SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] X = '0, Y = '0;
  logic         Bin = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, Bout, out_valid;
  logic [W-1:0] Diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         Ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Bin(Bin), .in_valid(in_valid), .in_ready(in_ready),
    .Diff(Diff), .Bout(Bout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SERIAL_SUB_OVF_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic result, W-cycle latency, hold until out_ready.
  logic         m_busy = 1'b0;
  int           m_cnt  = 0;
  logic [W-1:0] m_exp_d = '0, m_last_d = '0;
  logic         m_exp_b = 1'b0, m_last_b = 1'b0;
  logic         m_exp_o = 1'b0, m_last_o = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0;
      m_last_d <= '0; m_last_b <= 1'b0; m_last_o <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        logic [W:0]   full;
        logic [W-1:0] dd;
        full = {1'b0, X} - {1'b0, Y} - {{W{1'b0}}, Bin};
        dd   = full[W-1:0];
        m_busy  <= 1'b1;
        m_cnt   <= 0;
        m_exp_d <= dd;
        m_exp_b <= ({1'b0, X} < ({1'b0, Y} + {{W{1'b0}}, Bin}));
        m_exp_o <= (X[W-1] ^ Y[W-1]) & (X[W-1] ^ dd[W-1]);
      end
    end else if (m_cnt < W) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == W - 1) begin
        m_last_d <= m_exp_d; m_last_b <= m_exp_b; m_last_o <= m_exp_o;
      end
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready",  in_ready,  !m_busy);
      chk("m_out_valid", out_valid, m_busy && (m_cnt == W));
      chk("m_diff",      Diff,      m_last_d);
      chk("m_bout",      Bout,      m_last_b);
`ifdef SERIAL_SUB_OVF_EN
      chk("m_ovf",       Ovf,       m_last_o);
`endif
    end
  end

  // One operation with literal expected results; hold cycles of backpressure with in_valid asserted.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input int hold);
    @(negedge clk);
    X = x; Y = y; Bin = bi; in_valid = 1'b1;
    chk("ready_before", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; X = ~x; Y = ~y; Bin = ~bi;
    repeat (W - 1) @(posedge clk);
    #1 chk("lat_early", out_valid, 1'b0);
    @(posedge clk);
    #1 chk("lat_valid", out_valid, 1'b1);
    chk("diff", Diff, ed);
    chk("bout", Bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", Ovf, eo);
`else
    if (eo) ; // overflow expectation only meaningful with the feature built in
`endif
    if (hold > 0) begin
      in_valid = 1'b1; X = 8'h33; Y = 8'h11;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_diff", Diff, ed);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 chk("rst_ready", in_ready, 1'b1);

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    // Abort an operation mid-shift; previous result must be cleared and nothing produced.
    @(negedge clk); X = 8'hAA; Y = 8'h55; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_diff", Diff, 0);
    chk("abort_ready", in_ready, 1'b1);
    repeat (W + 2) @(posedge clk);
    #1 chk("abort_no_result", out_valid, 1'b0);

    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    run_op(8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    run_op(8'hC8, 8'h37, 1'b0, 8'h91, 1'b0, 1'b0, 20);
    run_op(8'h01, 8'hC8, 1'b1, 8'h38, 1'b1, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
